// File: rtl/mux_scan_seq_pkg.sv
// Shared definitions for the scanning selector: FSM state encodings.
package mux_scan_seq_pkg;

    // Scan sequencer states; encodings are fixed so that external
    // decoders and debug probes can rely on them.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DWELL   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/mux_scan_seq_mux_slice.sv
// One selector channel: 2**SEL_W:1 multiplexer of DATA_W-bit words with an
// active-low strobe that forces the output to zero when high.
module mux_slice #(
    parameter int DATA_W = 1,
    parameter int SEL_W  = 2
) (
    input  logic [(2**SEL_W)*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]             sel,
    input  logic                         g_n,
    output logic [DATA_W-1:0]            y
);

    // Select the addressed word unless the strobe is inactive.
    always_comb begin
        y = '0;
        if (!g_n) begin
            y = in_data[int'(sel)*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/mux_scan_seq.sv
// Registered multi-channel selector with manual mode and an auto-scan
// sequencer that sweeps all select codes and hands samples out via valid/ready.
module mux_scan_seq
    import mux_scan_seq_pkg::*;
#(
    parameter int DATA_W  = 1,
    parameter int SEL_W   = 2,
    parameter int NUM_CH  = 2,
    parameter int DWELL_W = 4
) (
    input  logic                                in_clk,
    input  logic                                in_rst,
    input  logic [NUM_CH*(2**SEL_W)*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]                    in_sel,
    input  logic [NUM_CH-1:0]                   in_g_n,
    input  logic                                in_mode,
    input  logic                                in_start,
    input  logic [DWELL_W-1:0]                  in_dwell,
    input  logic                                in_ready,
    output logic [NUM_CH*DATA_W-1:0]            out_y,
    output logic [SEL_W-1:0]                    out_sel,
    output logic                                out_valid,
    output logic                                out_busy,
    output logic                                out_done
);

    localparam int NUM_IN = 2**SEL_W;
    localparam logic [SEL_W-1:0]   LAST_SEL = {SEL_W{1'b1}};
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    state_t                    state_q, state_d;
    logic [SEL_W-1:0]          sel_cnt_q, sel_cnt_d;
    logic [DWELL_W-1:0]        dwell_cnt_q, dwell_cnt_d;
    logic [DWELL_W-1:0]        dwell_eff_q, dwell_eff_d;
    logic [NUM_CH*DATA_W-1:0]  y_q, y_d;
    logic [SEL_W-1:0]          osel_q, osel_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [SEL_W-1:0]          cap_sel;
    logic [NUM_CH*DATA_W-1:0]  mux_y;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            mux_slice #(
                .DATA_W (DATA_W),
                .SEL_W  (SEL_W)
            ) u_slice (
                .in_data (in_data[c*NUM_IN*DATA_W +: NUM_IN*DATA_W]),
                .sel     (cap_sel),
                .g_n     (in_g_n[c]),
                .y       (mux_y[c*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // State and output registers; reset clears everything, aborting any scan.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= ST_IDLE;
            sel_cnt_q   <= '0;
            dwell_cnt_q <= '0;
            dwell_eff_q <= '0;
            y_q         <= '0;
            osel_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_cnt_q   <= sel_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            dwell_eff_q <= dwell_eff_d;
            y_q         <= y_d;
            osel_q      <= osel_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state, counter and capture logic for manual and scan operation.
    always_comb begin
        state_d     = state_q;
        sel_cnt_d   = sel_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        dwell_eff_d = dwell_eff_q;
        y_d         = y_q;
        osel_d      = osel_q;
        valid_d     = valid_q;
        cap_sel     = sel_cnt_q;

        case (state_q)
            ST_IDLE: begin
                cap_sel = in_sel;
                if (!in_mode) begin
                    y_d     = mux_y;
                    osel_d  = in_sel;
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    if (in_start) begin
                        dwell_eff_d = (in_dwell == '0) ? DWELL_ONE : in_dwell;
                        dwell_cnt_d = (in_dwell == '0) ? DWELL_ONE : in_dwell;
                        sel_cnt_d   = '0;
                        state_d     = ST_DWELL;
                    end
                end
            end
            ST_DWELL: begin
                dwell_cnt_d = dwell_cnt_q - 1'b1;
                if (dwell_cnt_q == DWELL_ONE) begin
                    y_d     = mux_y;
                    osel_d  = sel_cnt_q;
                    valid_d = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // The handshake edge is the first dwell cycle of the next
                // code, keeping the sample pitch at dwell_eff with no stalls.
                cap_sel = sel_cnt_q + 1'b1;
                if (in_ready) begin
                    if (sel_cnt_q == LAST_SEL) begin
                        valid_d = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        sel_cnt_d = sel_cnt_q + 1'b1;
                        if (dwell_eff_q == DWELL_ONE) begin
                            y_d     = mux_y;
                            osel_d  = cap_sel;
                            valid_d = 1'b1;
                        end else begin
                            valid_d     = 1'b0;
                            dwell_cnt_d = dwell_eff_q - 1'b1;
                            state_d     = ST_DWELL;
                        end
                    end
                end
            end
            ST_DONE: begin
                sel_cnt_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_DWELL) || (state_d == ST_PRESENT);
        done_d = (state_d == ST_DONE);
    end

    assign out_y     = y_q;
    assign out_sel   = osel_q;
    assign out_valid = valid_q;
    assign out_busy  = busy_q;
    assign out_done  = done_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Randomized self-checking bench for mux_scan_seq with a schedule-based model.
module tb_mux_scan_seq;

    localparam int DW    = 1;
    localparam int SW    = 2;
    localparam int NC    = 2;
    localparam int DWW   = 4;
    localparam int NI    = 4;
    localparam int IN_W  = NC*NI*DW;
    localparam int OUT_W = NC*DW;

    logic             in_clk = 1'b0;
    logic             in_rst;
    logic [IN_W-1:0]  in_data;
    logic [SW-1:0]    in_sel;
    logic [NC-1:0]    in_g_n;
    logic             in_mode;
    logic             in_start;
    logic [DWW-1:0]   in_dwell;
    logic             in_ready;
    logic [OUT_W-1:0] out_y;
    logic [SW-1:0]    out_sel;
    logic             out_valid;
    logic             out_busy;
    logic             out_done;

    int n_vec = 0;
    int n_err = 0;

    mux_scan_seq #(
        .DATA_W  (DW),
        .SEL_W   (SW),
        .NUM_CH  (NC),
        .DWELL_W (DWW)
    ) dut (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_g_n    (in_g_n),
        .in_mode   (in_mode),
        .in_start  (in_start),
        .in_dwell  (in_dwell),
        .in_ready  (in_ready),
        .out_y     (out_y),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_busy  (out_busy),
        .out_done  (out_done)
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference selection: each channel picks word 'code' unless its strobe is high.
    function automatic logic [OUT_W-1:0] ref_sel(input logic [IN_W-1:0] d,
                                                 input logic [NC-1:0] g, input int code);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int ch = 0; ch < NC; ch++) begin
            if (!g[ch]) r[ch*DW +: DW] = d[(ch*NI + code)*DW +: DW];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    // Scan: sample k is captured dwell_eff edges after start (k=0), or
    // dwell_eff-1 edges after the handshake of sample k-1; done follows the
    // last handshake. Inputs are re-randomized every cycle to prove capture timing.
    task automatic do_scan(input int dwell_in, input int ready_pct, input int stall_k,
                           input bit rand_strobe, input int strobe_k,
                           input bit fixed, input logic [IN_W-1:0] fix_val, input bit noise);
        int eff, k, cap_at, e, stalled;
        bit pending, finished, done_now;
        logic [OUT_W-1:0] exp_y;
        eff = (dwell_in == 0) ? 1 : dwell_in;
        in_mode  = 1'b1;
        in_start = 1'b1;
        in_dwell = DWW'(dwell_in);
        in_ready = 1'b0;
        in_g_n   = '0;
        in_data  = fixed ? fix_val : IN_W'($urandom);
        tick();
        check("start_busy", out_busy, 1);
        check("start_valid", out_valid, 0);
        e = 0; k = 0; cap_at = eff; stalled = 0;
        pending = 0; finished = 0; exp_y = '0;
        while (!finished && e < 600) begin
            in_data = fixed ? fix_val : IN_W'($urandom);
            in_g_n  = rand_strobe ? NC'($urandom) : '0;
            if (!pending && k == strobe_k && e + 1 == cap_at) in_g_n = 2'b10;
            if (pending && k == stall_k && stalled < 5) begin
                in_ready = 1'b0;
                stalled++;
            end else begin
                in_ready = ($urandom_range(99) < ready_pct);
            end
            if (noise) begin
                in_start = 1'($urandom);
                in_mode  = 1'($urandom);
                in_sel   = SW'($urandom);
                in_dwell = DWW'($urandom);
            end else begin
                in_start = 1'b0;
            end
            tick();
            e++;
            done_now = 0;
            if (pending && in_ready) begin
                pending = 0;
                if (k == NI-1) begin
                    finished = 1;
                    done_now = 1;
                end else begin
                    k++;
                    cap_at = e + eff - 1;
                end
            end
            if (!pending && !finished && e == cap_at) begin
                exp_y   = ref_sel(in_data, in_g_n, k);
                pending = 1;
            end
            check("scan_valid", out_valid, pending);
            check("scan_busy", out_busy, !finished);
            check("scan_done", out_done, done_now);
            if (pending) begin
                check("scan_y", out_y, exp_y);
                check("scan_sel", out_sel, k);
            end
        end
        if (!finished) check("scan_timeout", 0, 1);
        in_mode  = 1'b1;
        in_start = 1'b0;
        in_ready = 1'b0;
        tick();
        check("post_done", out_done, 0);
        check("post_busy", out_busy, 0);
        check("post_valid", out_valid, 0);
    endtask

    task automatic manual_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            in_mode  = 1'b0;
            in_start = 1'($urandom);
            in_sel   = SW'($urandom);
            in_data  = IN_W'($urandom);
            in_g_n   = NC'($urandom);
            in_ready = 1'($urandom);
            tick();
            check("man_y", out_y, ref_sel(in_data, in_g_n, int'(in_sel)));
            check("man_sel", out_sel, in_sel);
            check("man_valid", out_valid, 1);
            check("man_busy", out_busy, 0);
        end
    endtask

    initial begin
        in_rst = 1'b1; in_data = '0; in_sel = '0; in_g_n = '0; in_mode = 1'b0;
        in_start = 1'b0; in_dwell = '0; in_ready = 1'b0;
        tick();
        tick();
        check("rst_y", out_y, 0);
        check("rst_sel", out_sel, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", out_busy, 0);
        check("rst_done", out_done, 0);
        in_rst = 1'b0;

        // Manual mode: C=0100 on channel 0, select 2, then strobe channel 0 off.
        in_mode = 1'b0; in_g_n = 2'b00; in_data = 8'b0000_0100; in_sel = 2'd2;
        tick();
        check("man_dir_y0", out_y[0], 1);
        check("man_dir_sel", out_sel, 2);
        in_g_n = 2'b01;
        tick();
        check("man_dir_strobe", out_y[0], 0);
        manual_cycles(20);

        // Fixed-data scan, dwell 3, always ready: expect 10,01,10,01.
        do_scan(3, 100, -1, 0, -1, 1, 8'b0101_1010, 0);
        // Backpressure at code 1.
        do_scan(2, 100, 1, 0, -1, 0, '0, 0);
        // Dwell 0 acts as 1, with start/mode/sel/dwell noise while busy.
        do_scan(0, 100, -1, 0, -1, 0, '0, 1);
        // Channel 1 strobed at capture of code 2.
        do_scan(3, 100, -1, 0, 2, 0, '0, 0);
        // Random scans.
        for (int i = 0; i < 12; i++) begin
            do_scan($urandom_range(15), $urandom_range(30, 100), $urandom_range(0, 3),
                    1'($urandom), -1, 0, '0, 1'($urandom));
        end

        // Reset mid-scan.
        in_mode = 1'b1; in_start = 1'b1; in_dwell = 4'd2; in_ready = 1'b1;
        tick();
        in_start = 1'b0;
        repeat (3) tick();
        in_rst = 1'b1;
        tick();
        check("rst_mid_y", out_y, 0);
        check("rst_mid_sel", out_sel, 0);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_busy", out_busy, 0);
        check("rst_mid_done", out_done, 0);
        tick();
        in_rst = 1'b0;
        tick();
        check("rst_after_valid", out_valid, 0);
        check("rst_after_busy", out_busy, 0);
        manual_cycles(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
